// File: rtl/nibble_serial_adder.sv
// Nibble-serial sequencer around an external 4-bit adder: adds two WIDTH-bit
// operands one nibble per cycle, LSB first, chaining the carry between passes.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_s,
    input  logic             add_cy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES - 1);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_badWidth
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic             r_carry;
    logic [CNT_W-1:0] r_idx;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic [WIDTH-1:0] w_accNext;

    // Partial result with the current adder nibble merged in, so the final
    // pass can publish the complete sum on the same edge it is produced.
    always_comb begin
        w_accNext = r_acc;
        w_accNext[int'(r_idx) * 4 +: 4] = add_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_opa   <= '0;
            r_opb   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_opa   <= in_a;
                        r_opb   <= in_b;
                        r_carry <= in_cin;
                        r_idx   <= '0;
                        r_acc   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_acc   <= w_accNext;
                    r_carry <= add_cy;
                    r_opa   <= r_opa >> 4;
                    r_opb   <= r_opb >> 4;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_sum   <= w_accNext;
                        r_cout  <= add_cy;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign add_a     = (r_state == RUN) ? r_opa[3:0] : 4'h0;
    assign add_b     = (r_state == RUN) ? r_opb[3:0] : 4'h0;
    assign add_cin   = (r_state == RUN) ? r_carry : 1'b0;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed-vector bench for nibble_serial_adder: a 16-bit and a 4-bit build,
// each wired to a behavioural 4-bit adder on its add_* ports.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic [3:0]  add_a, add_b, add_s;
    logic        add_cin, add_cy;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        busy;

    logic        in_valid4 = 1'b0;
    logic        in_ready4;
    logic [3:0]  in_a4 = '0;
    logic [3:0]  in_b4 = '0;
    logic        in_cin4 = 1'b0;
    logic [3:0]  add_a4, add_b4, add_s4;
    logic        add_cin4, add_cy4;
    logic        out_valid4;
    logic        out_ready4 = 1'b1;
    logic [3:0]  out_sum4;
    logic        out_cout4;
    logic        busy4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign {add_cy, add_s}   = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
    assign {add_cy4, add_s4} = {1'b0, add_a4} + {1'b0, add_b4} + {4'b0, add_cin4};

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cy(add_cy),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .in_a(in_a4), .in_b(in_b4), .in_cin(in_cin4),
        .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
        .add_s(add_s4), .add_cy(add_cy4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_sum(out_sum4), .out_cout(out_cout4), .busy(busy4)
    );

    // Presents an operation for one edge; returns at the falling edge after acceptance.
    task automatic startOp(input logic [15:0] a, input logic [15:0] b, input logic cin);
        @(negedge clk);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts falling edges until out_valid rises, giving up after 20.
    task automatic waitDone(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (out_sum !== 16'h0000 || out_cout !== 1'b0) begin errors++; $display("[TB] FAIL reset_result: got %h/%b expected 0000/0", out_sum, out_cout); end
        checks++; if ({add_a, add_b, add_cin} !== 9'h000) begin errors++; $display("[TB] FAIL reset_adder_drive: got %h %h %b expected 0 0 0", add_a, add_b, add_cin); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero;
        int cycles;
        startOp(16'h0000, 16'h0000, 1'b0);
        waitDone(cycles);
        checks++; if (cycles !== 4) begin errors++; $display("[TB] FAIL zero_latency: got %0d expected 4", cycles); end
        checks++; if (out_sum !== 16'h0000 || out_cout !== 1'b0) begin errors++; $display("[TB] FAIL zero_result: got %h/%b expected 0000/0", out_sum, out_cout); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL zero_handshake: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
    endtask

    task automatic test_ripple;
        int cycles;
        startOp(16'hFFFF, 16'h0001, 1'b0);
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL ripple_run_flags: got busy=%b ready=%b expected 1/0", busy, in_ready); end
        checks++; if (add_a !== 4'hF || add_b !== 4'h1 || add_cin !== 1'b0) begin errors++; $display("[TB] FAIL ripple_first_drive: got %h %h %b expected F 1 0", add_a, add_b, add_cin); end
        @(negedge clk);
        checks++; if (add_a !== 4'hF || add_b !== 4'h0 || add_cin !== 1'b1) begin errors++; $display("[TB] FAIL ripple_second_drive: got %h %h %b expected F 0 1", add_a, add_b, add_cin); end
        waitDone(cycles);
        checks++; if (cycles !== 3) begin errors++; $display("[TB] FAIL ripple_latency: got %0d expected 3", cycles); end
        checks++; if (out_sum !== 16'h0000 || out_cout !== 1'b1) begin errors++; $display("[TB] FAIL ripple_result: got %h/%b expected 0000/1", out_sum, out_cout); end
        checks++; if ({add_a, add_b, add_cin} !== 9'h000) begin errors++; $display("[TB] FAIL ripple_done_drive: got %h %h %b expected 0 0 0", add_a, add_b, add_cin); end
        @(negedge clk);
    endtask

    task automatic test_all_ones;
        int cycles;
        startOp(16'hFFFF, 16'hFFFF, 1'b1);
        waitDone(cycles);
        checks++; if (out_sum !== 16'hFFFF || out_cout !== 1'b1) begin errors++; $display("[TB] FAIL all_ones_result: got %h/%b expected FFFF/1", out_sum, out_cout); end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int cycles;
        out_ready = 1'b0;
        startOp(16'hA5A5, 16'h5A5A, 1'b0);
        waitDone(cycles);
        checks++; if (cycles !== 4) begin errors++; $display("[TB] FAIL hold_latency: got %0d expected 4", cycles); end
        in_a     = 16'h0001;
        in_b     = 16'h0002;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1 || out_sum !== 16'hFFFF || out_cout !== 1'b0) begin errors++; $display("[TB] FAIL hold_stable: cycle %0d got %b %h/%b expected 1 FFFF/0", i, out_valid, out_sum, out_cout); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_in_ready: cycle %0d got %b expected 0", i, in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL hold_release: got valid=%b busy=%b ready=%b expected 0/0/1", out_valid, busy, in_ready); end
        checks++; if (out_sum !== 16'hFFFF) begin errors++; $display("[TB] FAIL hold_sum_kept: got %h expected FFFF", out_sum); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1 || add_a !== 4'h1 || add_b !== 4'h2) begin errors++; $display("[TB] FAIL hold_second_accept: got busy=%b %h %h expected 1 1 2", busy, add_a, add_b); end
        waitDone(cycles);
        checks++; if (out_sum !== 16'h0003 || out_cout !== 1'b0) begin errors++; $display("[TB] FAIL hold_second_result: got %h/%b expected 0003/0", out_sum, out_cout); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        int cycles;
        startOp(16'h1234, 16'h4321, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midrun_reset: got valid=%b ready=%b busy=%b expected 0/1/0", out_valid, in_ready, busy); end
        checks++; if (out_sum !== 16'h0000) begin errors++; $display("[TB] FAIL midrun_reset_sum: got %h expected 0000", out_sum); end
        @(negedge clk);
        rst_n = 1'b1;
        startOp(16'h1234, 16'h4321, 1'b0);
        waitDone(cycles);
        checks++; if (cycles !== 4 || out_sum !== 16'h5555 || out_cout !== 1'b0) begin errors++; $display("[TB] FAIL midrun_reissue: got %0d %h/%b expected 4 5555/0", cycles, out_sum, out_cout); end
        @(negedge clk);
    endtask

    task automatic test_width4;
        int cycles;
        @(negedge clk);
        in_a4     = 4'hF;
        in_b4     = 4'h1;
        in_cin4   = 1'b1;
        in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        cycles = 0;
        while (!out_valid4 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checks++; if (cycles !== 1) begin errors++; $display("[TB] FAIL w4_latency: got %0d expected 1", cycles); end
        checks++; if (out_sum4 !== 4'h1 || out_cout4 !== 1'b1) begin errors++; $display("[TB] FAIL w4_result: got %h/%b expected 1/1", out_sum4, out_cout4); end
        @(negedge clk);
        checks++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin errors++; $display("[TB] FAIL w4_handshake: got valid=%b ready=%b expected 0/1", out_valid4, in_ready4); end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_ripple();
        test_all_ones();
        test_backpressure();
        test_reset_mid_run();
        test_width4();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
